// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I execute stage.
package rv32i_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned BE_W      = XLEN / 8;

  localparam logic [XLEN-1:0] RV32I_RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV32I_TRAP_VECTOR_DEF  = 32'h0000_0040;

  typedef enum logic [1:0] {
    WIDTH_BYTE  = 2'd0,
    WIDTH_HWORD = 2'd1,
    WIDTH_WORD  = 2'd2
  } ld_st_width_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_REQ  = 2'd1,
    LOAD_WAIT = 2'd2,
    STORE_REQ = 2'd3
  } alu_state_t;

  // Natural-alignment check for a data access of the given width.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      WIDTH_HWORD: return lo[0];
      WIDTH_WORD:  return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_ld_st_align.sv
// Byte-lane steering: store byte enables/replication and load lane select/extend.
module rv32i_ld_st_align
  import rv32i_pkg::*;
(
  input  logic [1:0]      width,
  input  logic            ld_unsigned,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] readdata,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] load_val_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfword lane uses addr_lo[1] only, so a misaligned access truncates.
  assign ld_byte = readdata[{addr_lo, 3'b000} +: 8];
  assign ld_half = readdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be_c    = 4'hF;
    wdata_c = store_data;
    case (width)
      WIDTH_BYTE: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{store_data[7:0]}};
      end
      WIDTH_HWORD: begin
        be_c    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_val_c = readdata;
    case (width)
      WIDTH_BYTE:  load_val_c = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      WIDTH_HWORD: load_val_c = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute stage: ALU, branch/jump/trap redirect and data-memory access FSM.
// Optional misaligned-access/target trap enabled by RV32I_ALU_MISALIGN_TRAP_EN.
module rv32i_alu
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RV32I_RESET_VECTOR = RV32I_RESET_VECTOR_DEF
`ifdef RV32I_ALU_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] RV32I_TRAP_VECTOR  = RV32I_TRAP_VECTOR_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [REG_IDX_W-1:0] a_rs_idx,
  input  logic [REG_IDX_W-1:0] b_rs_idx,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic [XLEN-1:0]      offset,
  input  logic [XLEN-1:0]      pc,
  input  logic                 branch,
  input  logic                 jump,
  input  logic                 system,
  input  logic                 load,
  input  logic                 store,
  input  logic [1:0]           ld_st_width,
  input  logic                 ld_unsigned,
  input  logic                 arith,
  input  logic                 add_nsub,
  input  logic                 cmp_unsigned,
  input  logic                 cmp_is_lt,
  input  logic                 cmp_is_ge,
  input  logic                 cmp_is_eq,
  input  logic                 cmp_is_ne,
  input  logic                 bit_is_and,
  input  logic                 bit_is_or,
  input  logic                 bit_is_xor,
  input  logic                 shift_arith,
  input  logic                 shift_left,
  input  logic                 shift_right,
  output logic [REG_IDX_W-1:0] fb_rd,
  output logic [XLEN-1:0]      fb_rd_val,
  output logic                 update_pc,
  output logic [XLEN-1:0]      new_pc,
  output logic                 stall,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [BE_W-1:0]      mem_be,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic                 mem_waitrequest,
  input  logic [XLEN-1:0]      mem_readdata,
  input  logic                 mem_readdatavalid
);

  alu_state_t state, state_nx;

  logic [REG_IDX_W-1:0] fb_rd_nx, acc_rd, acc_rd_nx;
  logic [XLEN-1:0]      fb_rd_val_nx, new_pc_nx, mem_addr_nx, mem_wdata_nx;
  logic [BE_W-1:0]      mem_be_nx;
  logic                 update_pc_nx, stall_nx, mem_read_nx, mem_write_nx;
  logic [1:0]           acc_width, acc_width_nx, acc_lo, acc_lo_nx;
  logic                 acc_unsigned, acc_unsigned_nx;

  logic [XLEN-1:0] op_a, op_b, result, eff_addr, jump_tgt, branch_tgt;
  logic            eq, lt, branch_taken, trap, load_done;

  logic [1:0]      align_width, align_lo;
  logic [BE_W-1:0] st_be;
  logic [XLEN-1:0] st_wdata, ld_val;

  // Forward the previous writeback for a back-to-back dependency.
  assign op_a = (a_rs_idx != '0 && a_rs_idx == fb_rd) ? fb_rd_val : a;
  assign op_b = (b_rs_idx != '0 && b_rs_idx == fb_rd) ? fb_rd_val : b;

  assign eq         = op_a == op_b;
  assign lt         = cmp_unsigned ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
  assign eff_addr   = op_a + offset;
  assign jump_tgt   = (op_a + op_b) & ~32'd1;
  assign branch_tgt = pc + offset;
  assign branch_taken = branch && ((cmp_is_eq && eq) || (cmp_is_ne && !eq) ||
                                   (cmp_is_lt && lt) || (cmp_is_ge && !lt));

  always_comb begin
    result = '0;
    if (jump)                        result = pc + 32'd4;
    else if (arith)                  result = add_nsub ? op_a + op_b : op_a - op_b;
    else if (cmp_is_lt && !branch)   result = {31'b0, lt};
    else if (bit_is_and)             result = op_a & op_b;
    else if (bit_is_or)              result = op_a | op_b;
    else if (bit_is_xor)             result = op_a ^ op_b;
    else if (shift_left)             result = op_a << op_b[4:0];
    else if (shift_right)            result = shift_arith ? XLEN'($signed(op_a) >>> op_b[4:0])
                                                          : op_a >> op_b[4:0];
  end

`ifdef RV32I_ALU_MISALIGN_TRAP_EN
  assign trap = (state == IDLE) &&
                (((load || store) && misaligned(ld_st_width, eff_addr[1:0])) ||
                 (jump && jump_tgt[1]) || (branch_taken && branch_tgt[1]));
`else
  assign trap = 1'b0;
`endif

  // Store steering uses live operands; load extraction uses the captured access.
  assign align_width = (state == IDLE) ? ld_st_width : acc_width;
  assign align_lo    = (state == IDLE) ? eff_addr[1:0] : acc_lo;

  rv32i_ld_st_align u_align (
    .width      (align_width),
    .ld_unsigned(acc_unsigned),
    .addr_lo    (align_lo),
    .store_data (op_b),
    .readdata   (mem_readdata),
    .be_c       (st_be),
    .wdata_c    (st_wdata),
    .load_val_c (ld_val)
  );

  assign load_done = mem_readdatavalid &&
                     ((state == LOAD_REQ && !mem_waitrequest) || state == LOAD_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fb_rd        <= '0;
      fb_rd_val    <= '0;
      update_pc    <= 1'b0;
      new_pc       <= RV32I_RESET_VECTOR;
      stall        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      acc_rd       <= '0;
      acc_width    <= '0;
      acc_lo       <= '0;
      acc_unsigned <= 1'b0;
    end else begin
      state        <= state_nx;
      fb_rd        <= fb_rd_nx;
      fb_rd_val    <= fb_rd_val_nx;
      update_pc    <= update_pc_nx;
      new_pc       <= new_pc_nx;
      stall        <= stall_nx;
      mem_addr     <= mem_addr_nx;
      mem_wdata    <= mem_wdata_nx;
      mem_be       <= mem_be_nx;
      mem_read     <= mem_read_nx;
      mem_write    <= mem_write_nx;
      acc_rd       <= acc_rd_nx;
      acc_width    <= acc_width_nx;
      acc_lo       <= acc_lo_nx;
      acc_unsigned <= acc_unsigned_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!trap && load)       state_nx = LOAD_REQ;
        else if (!trap && store) state_nx = STORE_REQ;
      end
      LOAD_REQ:  if (!mem_waitrequest) state_nx = mem_readdatavalid ? IDLE : LOAD_WAIT;
      LOAD_WAIT: if (mem_readdatavalid) state_nx = IDLE;
      STORE_REQ: if (!mem_waitrequest) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    fb_rd_nx        = '0;
    fb_rd_val_nx    = fb_rd_val;
    update_pc_nx    = 1'b0;
    new_pc_nx       = new_pc;
    stall_nx        = stall;
    mem_addr_nx     = mem_addr;
    mem_wdata_nx    = mem_wdata;
    mem_be_nx       = mem_be;
    mem_read_nx     = mem_read;
    mem_write_nx    = mem_write;
    acc_rd_nx       = acc_rd;
    acc_width_nx    = acc_width;
    acc_lo_nx       = acc_lo;
    acc_unsigned_nx = acc_unsigned;
    case (state)
      IDLE: begin
        if (trap) begin
`ifdef RV32I_ALU_MISALIGN_TRAP_EN
          update_pc_nx = 1'b1;
          new_pc_nx    = RV32I_TRAP_VECTOR;
`endif
        end else if (load) begin
          mem_read_nx     = 1'b1;
          mem_addr_nx     = {eff_addr[XLEN-1:2], 2'b00};
          stall_nx        = 1'b1;
          acc_rd_nx       = rd;
          acc_width_nx    = ld_st_width;
          acc_lo_nx       = eff_addr[1:0];
          acc_unsigned_nx = ld_unsigned;
        end else if (store) begin
          mem_write_nx = 1'b1;
          mem_addr_nx  = {eff_addr[XLEN-1:2], 2'b00};
          mem_be_nx    = st_be;
          mem_wdata_nx = st_wdata;
          stall_nx     = 1'b1;
        end else begin
          if (!branch && !system) fb_rd_nx = rd;
          fb_rd_val_nx = result;
          if (jump) begin
            update_pc_nx = 1'b1;
            new_pc_nx    = jump_tgt;
          end else if (branch_taken) begin
            update_pc_nx = 1'b1;
            new_pc_nx    = branch_tgt;
          end else if (system) begin
            update_pc_nx = 1'b1;
            new_pc_nx    = op_b;
          end
        end
      end
      LOAD_REQ: if (!mem_waitrequest) mem_read_nx = 1'b0;
      STORE_REQ: begin
        if (!mem_waitrequest) begin
          mem_write_nx = 1'b0;
          mem_be_nx    = '0;
          stall_nx     = 1'b0;
        end
      end
      default: ;
    endcase
    if (load_done) begin
      fb_rd_nx     = acc_rd;
      fb_rd_val_nx = ld_val;
      stall_nx     = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed self-checking bench for rv32i_alu.
module tb_rv32i_alu;

  logic        clk, reset;
  logic [4:0]  rd, a_rs_idx, b_rs_idx;
  logic [31:0] a, b, offset, pc;
  logic        branch, jump, system, load, store;
  logic [1:0]  ld_st_width;
  logic        ld_unsigned, arith, add_nsub;
  logic        cmp_unsigned, cmp_is_lt, cmp_is_ge, cmp_is_eq, cmp_is_ne;
  logic        bit_is_and, bit_is_or, bit_is_xor;
  logic        shift_arith, shift_left, shift_right;
  logic [4:0]  fb_rd;
  logic [31:0] fb_rd_val, new_pc, mem_addr, mem_wdata, mem_readdata;
  logic        update_pc, stall, mem_read, mem_write;
  logic [3:0]  mem_be;
  logic        mem_waitrequest, mem_readdatavalid;

  int total = 0;
  int bad   = 0;

  rv32i_alu #(.RV32I_RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .reset(reset),
    .rd(rd), .a_rs_idx(a_rs_idx), .b_rs_idx(b_rs_idx),
    .a(a), .b(b), .offset(offset), .pc(pc),
    .branch(branch), .jump(jump), .system(system), .load(load), .store(store),
    .ld_st_width(ld_st_width), .ld_unsigned(ld_unsigned),
    .arith(arith), .add_nsub(add_nsub),
    .cmp_unsigned(cmp_unsigned), .cmp_is_lt(cmp_is_lt), .cmp_is_ge(cmp_is_ge),
    .cmp_is_eq(cmp_is_eq), .cmp_is_ne(cmp_is_ne),
    .bit_is_and(bit_is_and), .bit_is_or(bit_is_or), .bit_is_xor(bit_is_xor),
    .shift_arith(shift_arith), .shift_left(shift_left), .shift_right(shift_right),
    .fb_rd(fb_rd), .fb_rd_val(fb_rd_val), .update_pc(update_pc), .new_pc(new_pc),
    .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then stable and inputs may be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    rd = '0; a_rs_idx = '0; b_rs_idx = '0;
    a = '0; b = '0; offset = '0; pc = '0;
    branch = 0; jump = 0; system = 0; load = 0; store = 0;
    ld_st_width = 2'd0; ld_unsigned = 0; arith = 0; add_nsub = 0;
    cmp_unsigned = 0; cmp_is_lt = 0; cmp_is_ge = 0; cmp_is_eq = 0; cmp_is_ne = 0;
    bit_is_and = 0; bit_is_or = 0; bit_is_xor = 0;
    shift_arith = 0; shift_left = 0; shift_right = 0;
  endtask

  initial begin
    clear();
    reset = 1'b1;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    tick(); tick();
    chk("rst_fb_rd", 32'(fb_rd), 32'd0);
    chk("rst_fb_val", fb_rd_val, 32'd0);
    chk("rst_upd", 32'(update_pc), 32'd0);
    chk("rst_new_pc", new_pc, 32'h100);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    reset = 1'b0;

    // ADD then SUB with A bypassed from the ADD result
    rd = 5'd3; a = 32'd5; b = 32'd7; arith = 1; add_nsub = 1; a_rs_idx = 5'd1; b_rs_idx = 5'd2;
    tick();
    chk("add_rd", 32'(fb_rd), 32'd3);
    chk("add_val", fb_rd_val, 32'd12);
    clear(); rd = 5'd4; a_rs_idx = 5'd3; a = 32'hDEAD; b = 32'd2; arith = 1; add_nsub = 0;
    tick();
    chk("sub_bypass_val", fb_rd_val, 32'd10);
    chk("sub_upd", 32'(update_pc), 32'd0);

    // BLT signed taken, BLTU not taken, BEQ backward taken
    clear(); branch = 1; cmp_is_lt = 1; a = 32'hFFFF_FFFF; b = 32'd1; pc = 32'h100; offset = 32'h20;
    a_rs_idx = 5'd5; b_rs_idx = 5'd6;
    tick();
    chk("blt_upd", 32'(update_pc), 32'd1);
    chk("blt_new_pc", new_pc, 32'h120);
    chk("blt_fb_rd", 32'(fb_rd), 32'd0);
    cmp_unsigned = 1;
    tick();
    chk("bltu_upd", 32'(update_pc), 32'd0);
    chk("bltu_pc_held", new_pc, 32'h120);
    clear(); branch = 1; cmp_is_eq = 1; a = 32'd9; b = 32'd9; pc = 32'h300; offset = 32'hFFFF_FFF8;
    tick();
    chk("beq_upd", 32'(update_pc), 32'd1);
    chk("beq_new_pc", new_pc, 32'h2F8);

    // JALR
    clear(); jump = 1; a = 32'h1001; b = 32'd4; pc = 32'h200; rd = 5'd1;
    tick();
    chk("jalr_upd", 32'(update_pc), 32'd1);
    chk("jalr_new_pc", new_pc, 32'h1004);
    chk("jalr_rd", 32'(fb_rd), 32'd1);
    chk("jalr_link", fb_rd_val, 32'h204);

    // Compares, shifts, bitwise
    clear(); cmp_is_lt = 1; a = 32'hFFFF_FFFD; b = 32'd2; rd = 5'd7;
    tick(); chk("slt", fb_rd_val, 32'd1);
    cmp_unsigned = 1;
    tick(); chk("sltu", fb_rd_val, 32'd0);
    clear(); shift_right = 1; shift_arith = 1; a = 32'h8000_0000; b = 32'h24; rd = 5'd8;
    tick(); chk("sra", fb_rd_val, 32'hF800_0000);
    shift_arith = 0;
    tick(); chk("srl", fb_rd_val, 32'h0800_0000);
    clear(); shift_left = 1; a = 32'd1; b = 32'd31; rd = 5'd8;
    tick(); chk("sll", fb_rd_val, 32'h8000_0000);
    clear(); bit_is_xor = 1; a = 32'hF0F0; b = 32'hFF00; rd = 5'd8;
    tick(); chk("xor", fb_rd_val, 32'h0FF0);

    // B-operand bypass
    clear(); arith = 1; add_nsub = 1; a = 32'd1; b = 32'd2; rd = 5'd9;
    tick();
    clear(); arith = 1; add_nsub = 1; a = 32'd10; b = 32'hBAD; b_rs_idx = 5'd9; rd = 5'd11;
    tick(); chk("add_b_bypass", fb_rd_val, 32'd13);

    // ECALL redirect to trap vector in B
    clear(); system = 1; b = 32'h80;
    tick();
    chk("sys_upd", 32'(update_pc), 32'd1);
    chk("sys_new_pc", new_pc, 32'h80);
    chk("sys_fb_rd", 32'(fb_rd), 32'd0);

    clear();
    tick();
    chk("bubble_upd", 32'(update_pc), 32'd0);
    chk("bubble_fb_rd", 32'(fb_rd), 32'd0);

    // LB at 0x1003: two waitrequest cycles, data three cycles after acceptance
    clear(); load = 1; ld_st_width = 2'd0; a = 32'h1000; offset = 32'd3; rd = 5'd10;
    mem_waitrequest = 1'b1;
    tick();
    clear();
    chk("lb_read", 32'(mem_read), 32'd1);
    chk("lb_addr", mem_addr, 32'h1000);
    chk("lb_stall0", 32'(stall), 32'd1);
    tick();
    chk("lb_stall1", 32'(stall), 32'd1);
    chk("lb_read_held", 32'(mem_read), 32'd1);
    chk("lb_no_wb", 32'(fb_rd), 32'd0);
    tick();
    chk("lb_stall2", 32'(stall), 32'd1);
    mem_waitrequest = 1'b0;
    tick();
    chk("lb_read_drop", 32'(mem_read), 32'd0);
    chk("lb_stall3", 32'(stall), 32'd1);
    tick(); tick();
    chk("lb_stall5", 32'(stall), 32'd1);
    mem_readdata = 32'h8012_3456; mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("lb_rd", 32'(fb_rd), 32'd10);
    chk("lb_val", fb_rd_val, 32'hFFFF_FF80);
    chk("lb_stall_end", 32'(stall), 32'd0);
    tick();
    chk("lb_after_rd", 32'(fb_rd), 32'd0);

    // LBU with data returned in the acceptance cycle
    clear(); load = 1; ld_st_width = 2'd0; ld_unsigned = 1; a = 32'h1000; offset = 32'd3; rd = 5'd10;
    tick();
    clear();
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("lbu_val", fb_rd_val, 32'h0000_0080);
    chk("lbu_stall", 32'(stall), 32'd0);

    // SH at 0x1002 with one waitrequest cycle
    clear(); store = 1; ld_st_width = 2'd1; a = 32'h1002; b = 32'h1234_ABCD;
    mem_waitrequest = 1'b1;
    tick();
    clear();
    chk("sh_write", 32'(mem_write), 32'd1);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", mem_addr, 32'h1000);
    chk("sh_stall", 32'(stall), 32'd1);
    tick();
    chk("sh_write_held", 32'(mem_write), 32'd1);
    mem_waitrequest = 1'b0;
    tick();
    chk("sh_write_drop", 32'(mem_write), 32'd0);
    chk("sh_stall_end", 32'(stall), 32'd0);
    chk("sh_no_wb", 32'(fb_rd), 32'd0);
    tick();
    chk("sh_single", 32'(mem_write), 32'd0);

    // Reset while in LOAD_WAIT abandons the access
    clear(); load = 1; ld_st_width = 2'd2; a = 32'h2000; rd = 5'd12;
    tick();
    clear();
    tick();
    chk("rw_wait_stall", 32'(stall), 32'd1);
    chk("rw_wait_read", 32'(mem_read), 32'd0);
    reset = 1'b1;
    tick();
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_read", 32'(mem_read), 32'd0);
    chk("rw_new_pc", new_pc, 32'h100);
    reset = 1'b0;
    mem_readdata = 32'h55; mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("rw_late_rd", 32'(fb_rd), 32'd0);
    chk("rw_late_stall", 32'(stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
